// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } add_flags_t;

    // Legal geometry: at least two bits, 1..width slices, and equal-sized slices.
    function automatic bit check_stages(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry slice; also exposes the carry entering its top bit
// so the final slice can derive signed overflow.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] carry_s;

    // Ripple the carry through the slice, bit by bit.
    always_comb begin
        carry_s    = {(W+1){1'b0}};
        s          = {W{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = carry_s[W];
    assign c_msb_in = carry_s[W-1];

endmodule

// File: rtl/pipelined_adder_chk.sv
// Elaboration-time guard on the WIDTH/STAGES geometry of pipelined_adder.
module pipelined_adder_chk
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) ();

    if (!check_stages(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES equal slices,
// one register rank per slice, with a single global enable for backpressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    pipelined_adder_chk #(.WIDTH(WIDTH), .STAGES(STAGES)) u_chk ();

    add_op_e                       op_s;
    logic                          advance_s;
    logic [STAGES-1:0]             valid_r;
    logic [STAGES-1:0]             carry_r;
    logic [WIDTH-1:0]              a_r     [STAGES];
    logic [WIDTH-1:0]              b_r     [STAGES];
    logic [WIDTH-1:0]              sum_r   [STAGES];
    logic                          overflow_r;
    logic                          zero_r;

    logic [WIDTH-1:0]              stg_a_s    [STAGES];
    logic [WIDTH-1:0]              stg_b_s    [STAGES];
    logic [WIDTH-1:0]              stg_sum_s  [STAGES];
    logic [WIDTH-1:0]              stg_next_s [STAGES];
    logic [STAGES-1:0]             stg_cin_s;
    logic [STAGES-1:0][SLICE-1:0]  slice_s;
    logic [STAGES-1:0]             slice_cout_s;
    logic                          last_cmsb_s;
    logic                          overflow_s;
    logic                          zero_s;

    assign op_s      = add_op_e'(in_op);
    assign advance_s = ~valid_r[LAST] | out_ready;
    assign in_ready  = advance_s;

    // Stage operands: stage 0 from the ports (b inverted for SUB), later stages from the previous rank.
    always_comb begin
        stg_a_s[0]   = in_a;
        stg_b_s[0]   = (op_s == OP_SUB) ? ~in_b : in_b;
        stg_cin_s    = {STAGES{1'b0}};
        stg_cin_s[0] = (op_s == OP_SUB) ? 1'b1 : 1'b0;
        stg_sum_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            stg_a_s[k]   = a_r[k-1];
            stg_b_s[k]   = b_r[k-1];
            stg_cin_s[k] = carry_r[k-1];
            stg_sum_s[k] = sum_r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == LAST) begin : g_last
            adder_slice #(.W(SLICE)) u_slice (
                .a        (stg_a_s[k][k*SLICE +: SLICE]),
                .b        (stg_b_s[k][k*SLICE +: SLICE]),
                .cin      (stg_cin_s[k]),
                .s        (slice_s[k]),
                .cout     (slice_cout_s[k]),
                .c_msb_in (last_cmsb_s)
            );
        end else begin : g_mid
            logic cmsb_unused_s;
            adder_slice #(.W(SLICE)) u_slice (
                .a        (stg_a_s[k][k*SLICE +: SLICE]),
                .b        (stg_b_s[k][k*SLICE +: SLICE]),
                .cin      (stg_cin_s[k]),
                .s        (slice_s[k]),
                .cout     (slice_cout_s[k]),
                .c_msb_in (cmsb_unused_s)
            );
        end
    end

    // Merge each stage's freshly computed slice into the partial result it carries along.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stg_next_s[k]                  = stg_sum_s[k];
            stg_next_s[k][k*SLICE +: SLICE] = slice_s[k];
        end
    end

    // Flags come from the last slice, on the fully assembled result.
    always_comb begin
        overflow_s = last_cmsb_s ^ slice_cout_s[LAST];
        zero_s     = (stg_next_s[LAST] == {WIDTH{1'b0}});
    end

    // Pipeline ranks: everything shifts together when the output side can take a word, else holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r    <= {STAGES{1'b0}};
            carry_r    <= {STAGES{1'b0}};
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            valid_r[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]     <= stg_a_s[k];
                b_r[k]     <= stg_b_s[k];
                sum_r[k]   <= stg_next_s[k];
                carry_r[k] <= slice_cout_s[k];
            end
            overflow_r <= overflow_s;
            zero_r     <= zero_s;
        end
    end

    assign out_valid    = valid_r[LAST];
    assign out_sum      = sum_r[LAST];
    assign out_carry    = carry_r[LAST];
    assign out_overflow = overflow_r;
    assign out_zero     = zero_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder at (32,4), (32,1) and (8,8) sharing one
// stimulus stream, plus backpressure and random streaming on the (32,4) instance.
module tb_pipelined_adder;
    import adder_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_op;
    logic        out_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic        in_ready0, out_valid0, out_carry0, out_overflow0, out_zero0;
    logic [31:0] out_sum0;
    logic        in_ready1, out_valid1, out_carry1, out_overflow1, out_zero1;
    logic [31:0] out_sum1;
    logic        in_ready2, out_valid2, out_carry2, out_overflow2, out_zero2;
    logic [7:0]  out_sum2;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid0),
        .out_ready(out_ready), .out_sum(out_sum0), .out_carry(out_carry0),
        .out_overflow(out_overflow0), .out_zero(out_zero0)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1), .out_carry(out_carry1),
        .out_overflow(out_overflow1), .out_zero(out_zero1)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_op(in_op), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_carry(out_carry2),
        .out_overflow(out_overflow2), .out_zero(out_zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        add_op_e     op;
        logic [31:0] sum;
        add_flags_t  f;
    } vec_t;

    vec_t        tbl [11];
    int          stg_tab [3] = '{4, 1, 8};
    int          n_vec = 0;
    int          n_err = 0;
    int          sent;
    int          got;
    bit          stall_prev;
    logic [34:0] held;
    logic [34:0] exp_q [$];

    // Reference: plain unsigned/signed arithmetic, result packed as {carry, overflow, zero, sum}.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
        logic [31:0] mask, aa, bb, s;
        logic [32:0] full;
        logic        c, v, z, sa, sb, ss;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa   = a & mask;
        bb   = b & mask;
        full = 33'd0;
        if (op) begin
            s = (aa - bb) & mask;
            c = (aa >= bb);
        end else begin
            full = {1'b0, aa} + {1'b0, bb};
            s    = full[31:0] & mask;
            c    = full[w];
        end
        sa = aa[w-1];
        sb = bb[w-1];
        ss = s[w-1];
        v  = op ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        z  = (s == 32'd0);
        return {c, v, z, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic get_out(input int j, output logic v, output logic [31:0] s,
                           output logic c, output logic o, output logic z);
        case (j)
            0: begin v = out_valid0; s = out_sum0; c = out_carry0; o = out_overflow0; z = out_zero0; end
            1: begin v = out_valid1; s = out_sum1; c = out_carry1; o = out_overflow1; z = out_zero1; end
            default: begin
                v = out_valid2; s = {24'd0, out_sum2}; c = out_carry2; o = out_overflow2; z = out_zero2;
            end
        endcase
    endtask

    // One streaming cycle on dut0: drive, then check handshake, hold behaviour and scoreboard.
    task automatic stream_cycle(input bit iv, input logic [31:0] a, input logic [31:0] b,
                                input logic op, input bit ordy);
        logic [34:0] e, act;
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        #1;
        act = {out_carry0, out_overflow0, out_zero0, out_sum0};
        check("in_ready", in_ready0, !out_valid0 | ordy);
        if (stall_prev) begin
            check("hold_valid", out_valid0, 1'b1);
            check("hold_sum", act[31:0], held[31:0]);
            check("hold_flags", act[34:32], held[34:32]);
        end
        if (iv && in_ready0) begin
            exp_q.push_back(model(32, a, b, op));
            sent++;
        end
        if (out_valid0 && ordy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: got sum 0x%08h, expected no output", act[31:0]);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("stream%0d_sum", got), act[31:0], e[31:0]);
                check($sformatf("stream%0d_flags", got), act[34:32], e[34:32]);
            end
            got++;
        end
        stall_prev = out_valid0 && !ordy;
        held       = act;
    endtask

    initial begin
        logic        v, c, o, z;
        logic [31:0] s;
        logic [34:0] e;
        int          lat  [3];
        logic [34:0] capt [3];

        tbl[0]  = '{32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008, 3'b000};
        tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 3'b101};
        tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 3'b010};
        tbl[3]  = '{32'h0000_0005, 32'h0000_0003, OP_SUB, 32'h0000_0002, 3'b100};
        tbl[4]  = '{32'h0000_0003, 32'h0000_0005, OP_SUB, 32'hFFFF_FFFE, 3'b000};
        tbl[5]  = '{32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 3'b110};
        tbl[6]  = '{32'h0000_0007, 32'h0000_0007, OP_SUB, 32'h0000_0000, 3'b101};
        tbl[7]  = '{32'h1234_5678, 32'h0FED_CBA8, OP_ADD, 32'h2222_2220, 3'b000};
        tbl[8]  = '{32'h0000_0000, 32'h0000_0000, OP_ADD, 32'h0000_0000, 3'b001};
        tbl[9]  = '{32'h0000_0000, 32'h0000_0000, OP_SUB, 32'h0000_0000, 3'b101};
        tbl[10] = '{32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 3'b111};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        out_ready = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        #12;
        for (int j = 0; j < 3; j++) begin
            get_out(j, v, s, c, o, z);
            check($sformatf("rst_dut%0d_valid", j), v, 1'b0);
            check($sformatf("rst_dut%0d_sum", j), s, 32'd0);
            check($sformatf("rst_dut%0d_flags", j), {c, o, z}, 3'b000);
        end
        check("rst_in_ready", in_ready0, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: one op at a time, latency and result checked on every instance.
        for (int vi = 0; vi < 11; vi++) begin
            @(negedge clk);
            in_a      = tbl[vi].a;
            in_b      = tbl[vi].b;
            in_op     = tbl[vi].op;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", vi), in_ready0, 1'b1);
            for (int j = 0; j < 3; j++) lat[j] = -1;
            for (int n = 1; n <= 12; n++) begin
                @(negedge clk);
                in_valid = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    get_out(j, v, s, c, o, z);
                    if (v && lat[j] < 0) begin
                        lat[j]  = n;
                        capt[j] = {c, o, z, s};
                    end
                end
            end
            for (int j = 0; j < 3; j++) begin
                e = (j == 2) ? model(8, tbl[vi].a, tbl[vi].b, tbl[vi].op) : {tbl[vi].f, tbl[vi].sum};
                check($sformatf("v%0d_dut%0d_latency", vi, j), lat[j], stg_tab[j]);
                check($sformatf("v%0d_dut%0d_sum", vi, j), capt[j][31:0], e[31:0]);
                check($sformatf("v%0d_dut%0d_carry", vi, j), capt[j][34], e[34]);
                check($sformatf("v%0d_dut%0d_overflow", vi, j), capt[j][33], e[33]);
                check($sformatf("v%0d_dut%0d_zero", vi, j), capt[j][32], e[32]);
            end
        end

        // Reset while three ADDs are in flight: nothing may emerge afterwards.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = i;
            in_b     = 32'd1;
            in_op    = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            get_out(j, v, s, c, o, z);
            check($sformatf("midrst_dut%0d_valid", j), v, 1'b0);
            check($sformatf("midrst_dut%0d_sum", j), s, 32'd0);
            check($sformatf("midrst_dut%0d_flags", j), {c, o, z}, 3'b000);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                get_out(j, v, s, c, o, z);
                check($sformatf("postrst%0d_dut%0d_valid", n, j), v, 1'b0);
            end
        end

        // Backpressure: 8 back-to-back ops, consumer stalls on cycles 5..8.
        sent       = 0;
        got        = 0;
        stall_prev = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            stream_cycle(sent < 8, 32'(sent), 32'(sent * 3), 1'b0, !(cyc >= 5 && cyc <= 8));
        end
        check("bp_results", got, 8);
        check("bp_drained", exp_q.size(), 0);

        // Random valid/ready traffic against the scoreboard.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            stream_cycle((sent < 1000) && ($urandom_range(0, 3) != 0), $urandom, $urandom,
                         1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        check("rand_results", got, 1000);
        check("rand_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
